// File: rtl/conv_out_collector.sv
// Frame collector behind the 2D convolution core: stores one OUT_DIM x OUT_DIM result
// frame (optionally ReLU'd), tracks count/max/sum and serves 1-cycle-latency readback.
module conv_out_collector #(
  parameter int Width = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic [5:0]                  OUT_DIM,
  input  logic                        RELU_EN,
  input  logic                        IN_VALID,
  input  logic signed [Width-1:0]     IN_DATA,
  input  logic                        RD_EN,
  input  logic [AW-1:0]               RD_ADDR,
  output logic signed [Width-1:0]     RD_DATA,
  output logic                        RD_VALID,
  output logic                        BUSY,
  output logic                        FRAME_DONE,
  output logic [AW:0]                 COUNT,
  output logic signed [Width-1:0]     MAX_VAL,
  output logic signed [Width+AW-1:0]  SUM,
  output logic                        ERR
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  state_e                     state_q, state_d;
  logic [AW:0]                target_q, target_d;
  logic                       relu_q, relu_d;
  logic [AW:0]                count_q, count_d;
  logic signed [Width+AW-1:0] sum_q, sum_d;
  logic signed [Width-1:0]    max_q, max_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       rd_valid_q, rd_valid_d;
  logic signed [Width-1:0]    rd_data_q, rd_data_d;

  logic [Width-1:0]           mem [DEPTH];

  logic [11:0]                dim_sq;
  logic                       dim_ok;
  logic signed [Width-1:0]    sample;
  logic                       wr_en;

  always_comb begin
    dim_sq = 12'(OUT_DIM) * 12'(OUT_DIM);
    dim_ok = (OUT_DIM != 6'd0) && (dim_sq <= 12'(DEPTH));
    sample = (relu_q && IN_DATA[Width-1]) ? '0 : IN_DATA;
    wr_en  = (state_q == COLLECT) && IN_VALID && !START;
  end

  // NOTE: every next-state variable gets its hold value first, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    relu_d     = relu_q;
    count_d    = count_q;
    sum_d      = sum_q;
    max_d      = max_q;
    err_d      = err_q;
    done_d     = 1'b0;
    rd_valid_d = RD_EN;
    rd_data_d  = rd_data_q;

    // Addresses not yet written in this frame read as zero, so stale data from an
    // earlier frame never leaks out (and a same-address write is never bypassed).
    if (RD_EN) begin
      rd_data_d = ({1'b0, RD_ADDR} < count_q) ? $signed(mem[RD_ADDR]) : '0;
    end

    if (START) begin
      if (!dim_ok) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        target_d = (AW+1)'(dim_sq);
        relu_d   = RELU_EN;
        count_d  = '0;
        sum_d    = '0;
        max_d    = {1'b1, {(Width-1){1'b0}}};
        err_d    = 1'b0;
        state_d  = COLLECT;
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (IN_VALID) begin
            count_d = count_q + 1'b1;
            sum_d   = sum_q + {{AW{sample[Width-1]}}, sample};
            max_d   = (sample > max_q) ? sample : max_q;
            if (count_q == target_q - 1'b1) begin
              state_d = HOLD;
              done_d  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (IN_VALID) err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      target_q   <= '0;
      relu_q     <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      relu_q     <= relu_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: the buffer has no reset so it maps onto plain RAM; unwritten entries are
  // masked by the count check on the read side instead.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[count_q[AW-1:0]] <= sample;
  end

  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign BUSY       = (state_q == COLLECT);
  assign FRAME_DONE = done_q;
  assign COUNT      = count_q;
  assign MAX_VAL    = max_q;
  assign SUM        = sum_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Self-checking bench for conv_out_collector: directed scenarios plus randomized frames
// compared against a queue-based model of the stored frame.
module tb_conv_out_collector;
  localparam int W     = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic                     START = 1'b0;
  logic [5:0]               OUT_DIM = '0;
  logic                     RELU_EN = 1'b0;
  logic                     IN_VALID = 1'b0;
  logic signed [W-1:0]      IN_DATA = '0;
  logic                     RD_EN = 1'b0;
  logic [AW-1:0]            RD_ADDR = '0;
  logic signed [W-1:0]      RD_DATA;
  logic                     RD_VALID;
  logic                     BUSY;
  logic                     FRAME_DONE;
  logic [AW:0]              COUNT;
  logic signed [W-1:0]      MAX_VAL;
  logic signed [W+AW-1:0]   SUM;
  logic                     ERR;

  conv_out_collector #(.Width(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OUT_DIM(OUT_DIM), .RELU_EN(RELU_EN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .COUNT(COUNT), .MAX_VAL(MAX_VAL), .SUM(SUM), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the values the frame should hold, in write order.
  int model_buf[$];
  int done_cnt, done_at;
  logic busy_after_last;

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  function automatic int relu_of(int v, bit r);
    return (r && v < 0) ? 0 : v;
  endfunction

  function automatic int model_sum();
    int s = 0;
    foreach (model_buf[i]) s += model_buf[i];
    return s;
  endfunction

  function automatic int model_max();
    int m = -32768;
    foreach (model_buf[i]) if (model_buf[i] > m) m = model_buf[i];
    return m;
  endfunction

  function automatic int rand_s16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic do_start(int dim, bit relu);
    OUT_DIM = 6'(dim);
    RELU_EN = relu;
    START   = 1'b1;
    cycle();
    START   = 1'b0;
  endtask

  // Streams one frame with up to max_gap idle cycles before each sample, recording
  // when FRAME_DONE is seen and filling the model.
  task automatic run_frame(int dim, bit relu, int vals[$], int max_gap);
    do_start(dim, relu);
    model_buf.delete();
    done_cnt = 0;
    done_at  = -1;
    busy_after_last = 1'bx;
    foreach (vals[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        cycle();
        if (FRAME_DONE) done_cnt++;
      end
      IN_VALID = 1'b1;
      IN_DATA  = 16'(vals[i]);
      cycle();
      IN_VALID = 1'b0;
      model_buf.push_back(relu_of(vals[i], relu));
      if (FRAME_DONE) begin done_cnt++; done_at = i; end
      if (i == vals.size() - 1) busy_after_last = BUSY;
    end
    cycle();
    if (FRAME_DONE) done_cnt++;
  endtask

  task automatic do_read(int addr, output logic signed [W-1:0] data, output logic valid);
    RD_EN   = 1'b1;
    RD_ADDR = AW'(addr);
    cycle();
    RD_EN   = 1'b0;
    data    = RD_DATA;
    valid   = RD_VALID;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    #3;
    outs = {RD_DATA, RD_VALID, BUSY, FRAME_DONE, COUNT, MAX_VAL, SUM, ERR};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    #4 RST = 1'b1;
    cycle();
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_basic(bit relu, string tag);
    int v[$];
    logic signed [W-1:0] d, hold;
    logic vld;
    logic signed [W+AW-1:0] es;
    logic signed [W-1:0] em;
    v = {-3, 5, 7, -1};
    run_frame(2, relu, v, 0);
    es = (W+AW)'(model_sum());
    em = W'(model_max());
    n_cmp++; if (done_at !== 3) begin n_bad++; $display("FAIL %s_done_at: got %0d want 3", tag, done_at); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_cnt: got %0d want 1", tag, done_cnt); end
    n_cmp++; if (busy_after_last !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", tag, busy_after_last); end
    n_cmp++; if (COUNT !== 7'd4) begin n_bad++; $display("FAIL %s_count: got %0d want 4", tag, COUNT); end
    n_cmp++; if (SUM !== es) begin n_bad++; $display("FAIL %s_sum: got %0d want %0d", tag, SUM, es); end
    n_cmp++; if (MAX_VAL !== em) begin n_bad++; $display("FAIL %s_max: got %0d want %0d", tag, MAX_VAL, em); end
    for (int a = 0; a < 4; a++) begin
      do_read(a, d, vld);
      n_cmp++;
      if (vld !== 1'b1 || d !== W'(model_buf[a])) begin
        n_bad++; $display("FAIL %s_read%0d: got %0d/v%b want %0d/v1", tag, a, d, vld, model_buf[a]);
      end
    end
    do_read(5, d, vld);
    n_cmp++; if (vld !== 1'b1 || d !== '0) begin n_bad++; $display("FAIL %s_read_oob: got %0d/v%b want 0/v1", tag, d, vld); end
    do_read(2, d, vld);
    hold = W'(model_buf[2]);
    cycle();
    n_cmp++;
    if (RD_VALID !== 1'b0 || RD_DATA !== hold) begin
      n_bad++; $display("FAIL %s_read_hold: got %0d/v%b want %0d/v0", tag, RD_DATA, RD_VALID, hold);
    end
  endtask

  task automatic test_gaps();
    int v[$];
    v = {-5, -2, -9, -4};
    run_frame(2, 1'b0, v, 3);
    n_cmp++; if (MAX_VAL !== -16'sd2) begin n_bad++; $display("FAIL gaps_max: got %0d want -2", MAX_VAL); end
    n_cmp++; if (SUM !== -22'sd20) begin n_bad++; $display("FAIL gaps_sum: got %0d want -20", SUM); end
    n_cmp++; if (done_cnt !== 1 || done_at !== 3) begin n_bad++; $display("FAIL gaps_done: got cnt %0d at %0d want 1 at 3", done_cnt, done_at); end
  endtask

  task automatic test_err();
    logic [AW:0] prev_cnt;
    logic signed [W+AW-1:0] prev_sum;
    prev_cnt = COUNT;
    prev_sum = SUM;
    do_start(9, 1'b0);
    n_cmp++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin n_bad++; $display("FAIL err_dim9: got err %b busy %b want 1/0", ERR, BUSY); end
    n_cmp++; if (COUNT !== prev_cnt || SUM !== prev_sum) begin n_bad++; $display("FAIL err_stats_kept: got %0d/%0d want %0d/%0d", COUNT, SUM, prev_cnt, prev_sum); end
    do_start(0, 1'b0);
    n_cmp++; if (ERR !== 1'b1 || BUSY !== 1'b0) begin n_bad++; $display("FAIL err_dim0: got err %b busy %b want 1/0", ERR, BUSY); end
    do_start(3, 1'b0);
    n_cmp++; if (ERR !== 1'b0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL err_clear: got err %b busy %b want 0/1", ERR, BUSY); end
    n_cmp++;
    if (COUNT !== '0 || SUM !== '0 || MAX_VAL !== -16'sd32768) begin
      n_bad++; $display("FAIL start_init: got %0d/%0d/%0d want 0/0/-32768", COUNT, SUM, MAX_VAL);
    end
  endtask

  task automatic test_hold();
    int v[$];
    logic signed [W-1:0] d;
    logic vld;
    logic signed [W+AW-1:0] es;
    for (int i = 0; i < 4; i++) v.push_back(rand_s16());
    run_frame(2, 1'b0, v, 1);
    es = (W+AW)'(model_sum());
    IN_VALID = 1'b1;
    IN_DATA  = 16'sd99;
    cycle();
    IN_VALID = 1'b0;
    n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL hold_err: got %b want 1", ERR); end
    n_cmp++; if (COUNT !== 7'd4 || SUM !== es) begin n_bad++; $display("FAIL hold_stats: got %0d/%0d want 4/%0d", COUNT, SUM, es); end
    for (int a = 0; a < 4; a++) begin
      do_read(a, d, vld);
      n_cmp++; if (d !== W'(model_buf[a])) begin n_bad++; $display("FAIL hold_buf%0d: got %0d want %0d", a, d, model_buf[a]); end
    end
  endtask

  task automatic test_restart();
    int v[$];
    logic signed [W-1:0] d;
    logic vld;
    do_start(2, 1'b0);
    IN_VALID = 1'b1; IN_DATA = 16'sd10; cycle();
    IN_DATA = 16'sd20; cycle();
    IN_DATA = 16'sd55; START = 1'b1; cycle();
    START = 1'b0; IN_VALID = 1'b0;
    n_cmp++; if (COUNT !== '0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL restart_drop: got cnt %0d busy %b want 0/1", COUNT, BUSY); end
    model_buf.delete();
    v = {1, 2, 3, 4};
    done_cnt = 0;
    foreach (v[i]) begin
      IN_VALID = 1'b1; IN_DATA = 16'(v[i]); cycle();
      model_buf.push_back(v[i]);
      if (FRAME_DONE) done_cnt++;
    end
    IN_VALID = 1'b0;
    n_cmp++; if (COUNT !== 7'd4 || SUM !== 22'sd10 || MAX_VAL !== 16'sd4) begin n_bad++; $display("FAIL restart_stats: got %0d/%0d/%0d want 4/10/4", COUNT, SUM, MAX_VAL); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
    for (int a = 0; a < 4; a++) begin
      do_read(a, d, vld);
      n_cmp++; if (d !== W'(model_buf[a])) begin n_bad++; $display("FAIL restart_buf%0d: got %0d want %0d", a, d, model_buf[a]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] outs;
    int seen = 0;
    do_start(2, 1'b0);
    RD_EN = 1'b1; RD_ADDR = '0;
    IN_VALID = 1'b1; IN_DATA = 16'sd10; cycle();
    IN_DATA = 16'sd20; cycle();
    IN_VALID = 1'b0; RD_EN = 1'b0;
    #2 RST = 1'b0;
    #1;
    outs = {RD_DATA, RD_VALID, BUSY, FRAME_DONE, COUNT, MAX_VAL, SUM, ERR};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL midreset_async: got %h want 0", outs); end
    cycle();
    #2 RST = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; IN_DATA = 16'(i + 30); cycle();
      if (FRAME_DONE) seen++;
    end
    IN_VALID = 1'b0;
    cycle();
    if (FRAME_DONE) seen++;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_done: got %0d pulses want 0", seen); end
    n_cmp++; if (COUNT !== '0 || ERR !== 1'b0 || BUSY !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: got cnt %0d err %b busy %b want 0/0/0", COUNT, ERR, BUSY); end
  endtask

  task automatic test_random();
    int v[$];
    int dim, a, n;
    bit relu;
    logic signed [W-1:0] d, exp_d;
    logic vld;
    logic signed [W+AW-1:0] es;
    logic signed [W-1:0] em;
    for (int f = 0; f < 20; f++) begin
      dim  = $urandom_range(1, 8);
      relu = 1'($urandom);
      n    = dim * dim;
      v.delete();
      for (int i = 0; i < n; i++) v.push_back(rand_s16());
      run_frame(dim, relu, v, 2);
      es = (W+AW)'(model_sum());
      em = W'(model_max());
      n_cmp++; if (done_cnt !== 1 || done_at !== n - 1) begin n_bad++; $display("FAIL rnd%0d_done: got cnt %0d at %0d want 1 at %0d", f, done_cnt, done_at, n - 1); end
      n_cmp++; if (COUNT !== 7'(n)) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", f, COUNT, n); end
      n_cmp++; if (SUM !== es) begin n_bad++; $display("FAIL rnd%0d_sum: got %0d want %0d", f, SUM, es); end
      n_cmp++; if (MAX_VAL !== em) begin n_bad++; $display("FAIL rnd%0d_max: got %0d want %0d", f, MAX_VAL, em); end
      for (int r = 0; r < 5; r++) begin
        a = $urandom_range(0, DEPTH - 1);
        exp_d = (a < n) ? W'(model_buf[a]) : '0;
        do_read(a, d, vld);
        n_cmp++; if (vld !== 1'b1 || d !== exp_d) begin n_bad++; $display("FAIL rnd%0d_read%0d: got %0d/v%b want %0d/v1", f, a, d, vld, exp_d); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "relu");
    test_gaps();
    test_err();
    test_hold();
    test_restart();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
